// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: segment bytes, brightness/enable in, display pins and scan status out
interface seg7_scan_driver_if;
  logic            en_i;
  logic [3:0]      bright_i;
  logic [5:0][7:0] seg_i;
  logic [7:0]      seg_o;
  logic [5:0]      dig_o;
  logic [2:0]      digit_idx_o;
  logic            frame_o;
  modport master (output en_i, bright_i, seg_i, input seg_o, dig_o, digit_idx_o, frame_o);
  modport slave  (input en_i, bright_i, seg_i, output seg_o, dig_o, digit_idx_o, frame_o);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 6-digit multiplexed display scanner with per-frame snapshot, blanking, PWM and enable
module seg7_scan_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 16,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit DIG_ACTIVE_LOW = 1
) (
  input logic               clk_i,
  input logic               rst_i,
  seg7_scan_driver_if.slave bus
);
  localparam int CW = ($clog2(SCAN_DIV) > 4) ? $clog2(SCAN_DIV) : 4;
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0] DIG_OFF = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;
  logic [CW-1:0]   r_c, w_c_n;
  logic [2:0]      r_idx, w_idx_n;
  logic [5:0][7:0] r_shadow, w_shadow_n;
  logic            w_slot_end, w_wrap, w_on;
  logic [5:0]      w_onehot;
  // Outputs are registered from next-state values so they line up with the c/idx they describe
  always_comb begin
    w_slot_end = r_c == CW'(SCAN_DIV - 1);
    w_wrap     = w_slot_end && r_idx == 3'd5;
    w_c_n      = w_slot_end ? '0 : r_c + 1'b1;
    w_idx_n    = w_slot_end ? (w_wrap ? 3'd0 : r_idx + 3'd1) : r_idx;
    w_shadow_n = w_wrap ? bus.seg_i : r_shadow;
    w_on       = bus.en_i && w_c_n >= CW'(BLANK_CYC) && w_c_n[3:0] <= bus.bright_i;
    w_onehot   = 6'b1 << w_idx_n;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_c             <= '0;
      r_idx           <= '0;
      r_shadow        <= '0;
      bus.seg_o       <= SEG_OFF;
      bus.dig_o       <= DIG_OFF;
      bus.digit_idx_o <= '0;
      bus.frame_o     <= 1'b0;
    end else begin
      r_c             <= w_c_n;
      r_idx           <= w_idx_n;
      r_shadow        <= w_shadow_n;
      bus.seg_o       <= (bus.en_i ? w_shadow_n[w_idx_n] : 8'h00) ^ SEG_OFF;
      bus.dig_o       <= (w_on ? w_onehot : 6'h00) ^ DIG_OFF;
      bus.digit_idx_o <= w_idx_n;
      bus.frame_o     <= w_wrap;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized stimulus against a cycle-count model of the scan driver
module tb_seg7_scan_driver;
  localparam int SD = 20, BC = 2, FR = 6 * SD;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  seg7_scan_driver_if bus();
  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int errs = 0, checks = 0, t = 0, cnt = 0;
  logic [7:0] sh [6];
  logic       m_en;
  logic [3:0] m_br;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s t=%0d got=%h exp=%h", nm, t, act, exp);
    end
  endtask
  task automatic model_reset();
    t = 0;
    m_en = 0;
    m_br = 0;
    for (int k = 0; k < 6; k++) sh[k] = 8'h00;
  endtask
  task automatic check_model();
    int c, k;
    logic on;
    logic [5:0] e_dig;
    logic [7:0] e_seg;
    c = t % SD;
    k = (t / SD) % 6;
    on = m_en && c >= BC && (c % 16) <= int'(m_br);
    e_dig = on ? ~(6'b1 << k) : 6'h3F;
    e_seg = m_en ? ~sh[k] : 8'hFF;
    chk("dig", 32'(bus.dig_o), 32'(e_dig));
    chk("seg", 32'(bus.seg_o), 32'(e_seg));
    chk("idx", 32'(bus.digit_idx_o), 32'(k));
    chk("frame", 32'(bus.frame_o), 32'(t > 0 && t % FR == 0));
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (t % FR == FR - 1) for (int k = 0; k < 6; k++) sh[k] = bus.seg_i[k];
      m_en = bus.en_i;
      m_br = bus.bright_i;
      t++;
    end
    @(negedge clk);
    check_model();
  endtask
  task automatic run_to(input int n);
    while (t < n) tick();
  endtask
  initial begin
    model_reset();
    bus.en_i = 1'($urandom);
    bus.bright_i = 4'($urandom);
    for (int k = 0; k < 6; k++) bus.seg_i[k] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.en_i = 1'($urandom);
      bus.bright_i = 4'($urandom);
      bus.seg_i[i] = 8'($urandom);
    end
    chk("rst_dig", 32'(bus.dig_o), 32'h3F);
    chk("rst_seg", 32'(bus.seg_o), 32'hFF);
    bus.en_i = 1;
    bus.bright_i = 15;
    for (int k = 0; k < 6; k++) bus.seg_i[k] = 8'(8'h10 + k);
    rst = 0;
    run_to(119);
    chk("blank_frame_seg", 32'(bus.seg_o), 32'hFF);
    run_to(120);
    chk("first_frame", 32'(bus.frame_o), 32'h1);
    tick();
    chk("frame_one_cycle", 32'(bus.frame_o), 32'h0);
    run_to(125);
    chk("slot0_seg", 32'(bus.seg_o), 32'hEF);
    chk("slot0_dig", 32'(bus.dig_o), 32'h3E);
    run_to(223);
    chk("slot5_seg", 32'(bus.seg_o), 32'hEA);
    chk("slot5_dig", 32'(bus.dig_o), 32'h1F);
    run_to(285);
    chk("f2_slot2_seg", 32'(bus.seg_o), 32'hED);
    run_to(305);
    bus.seg_i[2] = 8'hFF;
    run_to(345);
    chk("f2_slot2_hold", 32'(bus.digit_idx_o), 32'h5);
    run_to(405);
    chk("f3_slot2_seg", 32'(bus.seg_o), 32'h00);
    bus.bright_i = 3;
    run_to(419);
    cnt = 0;
    for (int i = 0; i < SD; i++) begin
      tick();
      if (bus.dig_o != 6'h3F) cnt++;
    end
    chk("bright3_lit", 32'(cnt), 32'd6);
    run_to(445);
    bus.en_i = 0;
    tick();
    chk("en_off_dig", 32'(bus.dig_o), 32'h3F);
    chk("en_off_seg", 32'(bus.seg_o), 32'hFF);
    cnt = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (bus.frame_o) cnt++;
    end
    chk("en_off_frames", 32'(cnt), 32'd1);
    bus.en_i = 1;
    bus.bright_i = 15;
    for (int i = 0; i < 2 * SD; i++) tick();
    for (int i = 0; i < 1500; i++) begin
      tick();
      if ($urandom_range(0, 9) == 0) bus.en_i = 1'($urandom);
      if ($urandom_range(0, 4) == 0) bus.bright_i = 4'($urandom);
      if ($urandom_range(0, 2) == 0) bus.seg_i[$urandom_range(0, 5)] = 8'($urandom);
    end
    bus.en_i = 1;
    for (int i = 0; i < FR && !((t / SD) % 6 == 3 && t % SD == 7); i++) tick();
    chk("reach_slot3", 32'((t / SD) % 6), 32'd3);
    rst = 1;
    model_reset();
    #1;
    chk("mid_rst_dig", 32'(bus.dig_o), 32'h3F);
    chk("mid_rst_seg", 32'(bus.seg_o), 32'hFF);
    chk("mid_rst_idx", 32'(bus.digit_idx_o), 32'h0);
    chk("mid_rst_frame", 32'(bus.frame_o), 32'h0);
    for (int i = 0; i < 3; i++) tick();
    rst = 0;
    cnt = 0;
    for (int i = 0; i < FR - 1; i++) begin
      tick();
      if (bus.frame_o) cnt++;
      if (i % 7 == 0) bus.seg_i[$urandom_range(0, 5)] = 8'($urandom);
    end
    chk("post_rst_no_frame", 32'(cnt), 32'd0);
    tick();
    chk("post_rst_frame120", 32'(bus.frame_o), 32'h1);
    for (int i = 0; i < 2 * SD; i++) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
